// File: rtl/dcache_arbiter.sv
// Round-robin arbiter sharing the single-port 32x32 dcache between p0 (execute) and p1 (debug/fill).
// Optional perf counters are enabled by defining DCACHE_ARB_PERF_EN.
module dcache_arbiter #(
  parameter logic [3:0]  STR_UOP    = 4'b1001,
  parameter logic [3:0]  LDR_UOP    = 4'b1010,
  parameter logic [3:0]  NOP_UOP    = 4'b0000,
  parameter int unsigned PERF_CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_write,
  input  logic [4:0]  p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_write,
  input  logic [4:0]  p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic [4:0]  dcache_addr,
  output logic [31:0] dcache_data_in,
  output logic [3:0]  dcache_uop,
  input  logic [31:0] dcache_data_out
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_p0_grants,
  output logic [PERF_CNT_W-1:0] perf_p1_grants,
  output logic [PERF_CNT_W-1:0] perf_conflicts
`endif
);

  if (PERF_CNT_W == 0) begin : g_bad_perf_w
    $error("PERF_CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state, next_state;
  logic   last_grant;
  logic   cur_port;
  logic   cur_write;
  logic   win0, win1, accept;
  logic   sel_write;
  logic [4:0]  sel_addr;
  logic [31:0] sel_wdata;

  always_comb begin
    // On a tie the port that did not win last time goes; last_grant resets to 1 so p0 wins first.
    win0         = p0_req_valid && (!p1_req_valid || last_grant);
    win1         = p1_req_valid && (!p0_req_valid || !last_grant);
    p0_req_ready = (state == IDLE) && win0;
    p1_req_ready = (state == IDLE) && win1;
    accept       = p0_req_ready || p1_req_ready;
    sel_write    = p1_req_ready ? p1_req_write : p0_req_write;
    sel_addr     = p1_req_ready ? p1_req_addr  : p0_req_addr;
    sel_wdata    = p1_req_ready ? p1_req_wdata : p0_req_wdata;
    next_state   = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   next_state = cur_write ? IDLE : CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant     <= 1'b1;
      cur_port       <= 1'b0;
      cur_write      <= 1'b0;
      dcache_addr    <= '0;
      dcache_data_in <= '0;
      dcache_uop     <= NOP_UOP;
      p0_resp_valid  <= 1'b0;
      p1_resp_valid  <= 1'b0;
      p0_resp_rdata  <= '0;
      p1_resp_rdata  <= '0;
    end else begin
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      if (accept) begin
        last_grant     <= p1_req_ready;
        cur_port       <= p1_req_ready;
        cur_write      <= sel_write;
        dcache_addr    <= sel_addr;
        dcache_data_in <= sel_wdata;
        dcache_uop     <= sel_write ? STR_UOP : LDR_UOP;
      end
      if (state == ISSUE) begin
        dcache_uop <= NOP_UOP;
        if (cur_write) begin
          if (cur_port) begin
            p1_resp_valid <= 1'b1;
            p1_resp_rdata <= '0;
          end else begin
            p0_resp_valid <= 1'b1;
            p0_resp_rdata <= '0;
          end
        end
      end
      if (state == CAPTURE) begin
        if (cur_port) begin
          p1_resp_valid <= 1'b1;
          p1_resp_rdata <= dcache_data_out;
        end else begin
          p0_resp_valid <= 1'b1;
          p0_resp_rdata <= dcache_data_out;
        end
      end
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_p0_grants <= '0;
      perf_p1_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (p0_req_ready && (perf_p0_grants != '1)) perf_p0_grants <= perf_p0_grants + 1'b1;
      if (p1_req_ready && (perf_p1_grants != '1)) perf_p1_grants <= perf_p1_grants + 1'b1;
      if ((state == IDLE) && p0_req_valid && p1_req_valid && (perf_conflicts != '1))
        perf_conflicts <= perf_conflicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_arbiter.sv
// Randomized + directed bench for dcache_arbiter against a transaction-level model
// (memory array, grant history, predicted response cycle per accepted request).
module tb_dcache_arbiter;
  localparam logic [3:0] STR = 4'b1001;
  localparam logic [3:0] LDR = 4'b1010;
  localparam logic [3:0] NOP = 4'b0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1, rv0, rv1;
  logic [31:0] rd0, rd1;
  logic [4:0]  dc_addr;
  logic [31:0] dc_din;
  logic [31:0] dc_dout = '0;
  logic [3:0]  dc_uop;
`ifdef DCACHE_ARB_PERF_EN
  logic [15:0] pf_g0, pf_g1, pf_cf;
`endif

  dcache_arbiter #(.STR_UOP(STR), .LDR_UOP(LDR), .NOP_UOP(NOP), .PERF_CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req_valid(v0), .p0_req_ready(r0), .p0_req_write(w0), .p0_req_addr(a0),
    .p0_req_wdata(d0), .p0_resp_valid(rv0), .p0_resp_rdata(rd0),
    .p1_req_valid(v1), .p1_req_ready(r1), .p1_req_write(w1), .p1_req_addr(a1),
    .p1_req_wdata(d1), .p1_resp_valid(rv1), .p1_resp_rdata(rd1),
    .dcache_addr(dc_addr), .dcache_data_in(dc_din), .dcache_uop(dc_uop),
    .dcache_data_out(dc_dout)
`ifdef DCACHE_ARB_PERF_EN
    , .perf_p0_grants(pf_g0), .perf_p1_grants(pf_g1), .perf_conflicts(pf_cf)
`endif
  );

  always #5 clock = ~clock;

  // Unreset single-port dcache: op performed at the end of the cycle its uop is presented.
  logic [31:0] dmem [32];
  always @(posedge clock) begin
    if (dc_uop == STR) dmem[dc_addr] <= dc_din;
    if (dc_uop == LDR) dc_dout <= dmem[dc_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction in flight, described by when it issues and when it answers.
  int          cyc = 0;
  bit          lg;
  int          free_cyc, iss_cyc, resp_due;
  bit          resp_port, iss_w;
  logic [4:0]  iss_a;
  logic [31:0] iss_d, resp_data;
  logic [31:0] ref_mem [32];
  logic [31:0] last_rd [2];
  bit          acc0, acc1;
  int          grants [2];
  int          conflicts;
  bit          seq [$];
  logic [3:0]  uop_log [$];

  task automatic model_reset();
    lg = 1'b1; free_cyc = cyc; iss_cyc = -100; resp_due = -100;
    last_rd[0] = '0; last_rd[1] = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    grants[0] = 0; grants[1] = 0; conflicts = 0;
  endtask

  task automatic check_cycle();
    bit idle, e0, e1, p, w, exp_rv0, exp_rv1;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  exp_uop;
    idle = (cyc >= free_cyc);
    e0 = idle && v0 && (!v1 || lg);
    e1 = idle && v1 && (!v0 || !lg);
    check("p0_ready", r0, e0);
    check("p1_ready", r1, e1);
    exp_rv0 = (resp_due == cyc) && !resp_port;
    exp_rv1 = (resp_due == cyc) && resp_port;
    if (exp_rv0) last_rd[0] = resp_data;
    if (exp_rv1) last_rd[1] = resp_data;
    check("p0_resp_valid", rv0, exp_rv0);
    check("p1_resp_valid", rv1, exp_rv1);
    check("p0_resp_rdata", rd0, last_rd[0]);
    check("p1_resp_rdata", rd1, last_rd[1]);
    exp_uop = (cyc == iss_cyc) ? (iss_w ? STR : LDR) : NOP;
    check("dcache_uop", dc_uop, exp_uop);
    uop_log.push_back(dc_uop);
    if (cyc == iss_cyc) begin
      check("dcache_addr", dc_addr, iss_a);
      if (iss_w) check("dcache_data_in", dc_din, iss_d);
    end
    if (idle && v0 && v1) conflicts++;
    acc0 = e0; acc1 = e1;
    if (e0 || e1) begin
      p = e1;
      w = p ? w1 : w0;
      a = p ? a1 : a0;
      d = p ? d1 : d0;
      lg = p;
      iss_cyc = cyc + 1; iss_w = w; iss_a = a; iss_d = d;
      free_cyc = cyc + (w ? 2 : 3);
      resp_due = free_cyc;
      resp_port = p;
      resp_data = w ? 32'h0 : ref_mem[a];
      if (w) ref_mem[a] = d;
      grants[p]++;
      seq.push_back(p);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 units before the next one.
  task automatic tick();
    #7;
    check_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_req(input bit p, input bit w, input logic [4:0] a, input logic [31:0] d);
    bit done;
    done = 1'b0;
    if (p) begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
    else   begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; end
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = p ? acc1 : acc0;
    end
    if (!done) check("req_accept_timeout", 32'd0, 32'd1);
    if (p) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_values();
    check("rst_p0_ready", r0, 0);
    check("rst_p1_ready", r1, 0);
    check("rst_p0_resp_valid", rv0, 0);
    check("rst_p1_resp_valid", rv1, 0);
    check("rst_p0_resp_rdata", rd0, 0);
    check("rst_p1_resp_rdata", rd1, 0);
    check("rst_dcache_addr", dc_addr, 0);
    check("rst_dcache_data_in", dc_din, 0);
    check("rst_dcache_uop", dc_uop, NOP);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int base;
    logic [3:0] exp_seq [7];
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    reset_n = 1'b1;
    model_reset();

    // Fill every word so later loads have a known expectation.
    for (int i = 0; i < 32; i++) do_req(i[0], 1'b1, i[4:0], $urandom);
    idle_n(2);

    do_req(0, 1'b1, 5'd3, 32'hDEADBEEF);
    do_req(0, 1'b0, 5'd3, 32'h0);
    idle_n(4);
    check("load_after_store", rd0, 32'hDEADBEEF);

    // Wrap-around addresses with uop trace.
    base = uop_log.size();
    do_req(0, 1'b1, 5'd31, 32'h1357_9BDF);
    do_req(0, 1'b1, 5'd0,  32'hA5A5_0000);
    do_req(0, 1'b0, 5'd31, 32'h0);
    do_req(0, 1'b0, 5'd0,  32'h0);
    idle_n(4);
    exp_seq = '{STR, NOP, STR, NOP, LDR, NOP, NOP};
    for (int k = 0; k < 7; k++) check($sformatf("uop_seq%0d", k), uop_log[base + 1 + k], exp_seq[k]);
    check("wrap_addr0_data", rd0, 32'hA5A5_0000);

    for (int k = 0; k < 4; k++) do_req(1, 1'b0, 5'(k + 8), 32'h0);
    idle_n(4);

    // Both ports continuously valid right after reset: p0 first, then strict alternation.
    pulse_reset();
    base = seq.size();
    v0 = 1'b1; w0 = 1'b0; a0 = 5'd1;
    v1 = 1'b1; w1 = 1'b0; a1 = 5'd2;
    for (int i = 0; i < 100 && seq.size() < base + 16; i++) tick();
    v0 = 1'b0; v1 = 1'b0;
    idle_n(4);
    if (seq.size() < base + 16) check("alternation_timeout", seq.size(), base + 16);
    else for (int k = 0; k < 16; k++) check($sformatf("alt_grant%0d", k), seq[base + k], k % 2);

    // Reset asserted during CAPTURE of a p1 load: nothing answers, outputs clear at once.
    do_req(1, 1'b0, 5'd5, 32'h0);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clock);
    #1;
    cyc++;
    reset_n = 1'b1;
    model_reset();
    idle_n(2);
    do_req(0, 1'b0, 5'd5, 32'h0);
    idle_n(4);

    // Randomized traffic; an unaccepted request holds its fields or is withdrawn.
    for (int n = 0; n < 600; n++) begin
      if (v0 && !acc0) begin
        if ($urandom_range(7) == 0) v0 = 1'b0;
      end else begin
        v0 = 1'($urandom_range(1)); w0 = 1'($urandom_range(1));
        a0 = 5'($urandom_range(7)); d0 = $urandom;
      end
      if (v1 && !acc1) begin
        if ($urandom_range(7) == 0) v1 = 1'b0;
      end else begin
        v1 = 1'($urandom_range(1)); w1 = 1'($urandom_range(1));
        a1 = 5'($urandom_range(7)); d1 = $urandom;
      end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    idle_n(5);

`ifdef DCACHE_ARB_PERF_EN
    #7;
    check("perf_p0_grants", pf_g0, grants[0]);
    check("perf_p1_grants", pf_g1, grants[1]);
    check("perf_conflicts", pf_cf, conflicts);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
